// File: rtl/intern_sync_pkg.sv
// Shared types for the multi-channel internal reconfiguration synchroniser.
// Optional forced-ack timeout is enabled with macro INTERN_SYNC_TIMEOUT_EN.
package intern_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/intern_sync_ch.sv
// One reconfiguration channel: request/drain/ack FSM plus idle-run counter.
// Optional forced-ack timeout is enabled with macro INTERN_SYNC_TIMEOUT_EN.
module intern_sync_ch
    import intern_sync_pkg::*;
#(
    parameter int IDLE_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_reqn,
    input  logic i_is_idle,
    output logic o_ackn,
    output logic o_drain,
    output logic o_timeout
);

    localparam int IW = cnt_width(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_TGT = IW'(IDLE_CYCLES);

    if (IDLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("intern_sync_ch: IDLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idle_cnt;
    logic [IW-1:0]   w_idle_cnt_next;
    logic [IW-1:0]   w_idle_cnt_inc;
    logic            r_ackn;
    logic            r_drain;
    logic            w_ackn_next;
    logic            w_drain_next;

`ifdef INTERN_SYNC_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_TGT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0]   r_tmo_cnt;
    logic [TW-1:0]   w_tmo_cnt_next;
    logic            r_timeout;
    logic            w_timeout_next;
`endif

    // Saturating increment: the counter never wraps back below the target.
    assign w_idle_cnt_inc = (r_idle_cnt == IDLE_TGT) ? r_idle_cnt : r_idle_cnt + IW'(1);

    always_comb begin
        w_state_next    = r_state;
        w_idle_cnt_next = r_idle_cnt;
`ifdef INTERN_SYNC_TIMEOUT_EN
        w_tmo_cnt_next  = r_tmo_cnt;
        w_timeout_next  = r_timeout;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!i_reqn) begin
                    w_state_next    = ST_DRAIN;
                    w_idle_cnt_next = '0;
`ifdef INTERN_SYNC_TIMEOUT_EN
                    w_tmo_cnt_next  = '0;
                    w_timeout_next  = 1'b0;
`endif
                end
            end
            ST_DRAIN: begin
                w_idle_cnt_next = i_is_idle ? w_idle_cnt_inc : '0;
`ifdef INTERN_SYNC_TIMEOUT_EN
                w_tmo_cnt_next  = (r_tmo_cnt == TMO_TGT) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
`endif
                // Abort outranks completion, which outranks the timeout.
                if (i_reqn) begin
                    w_state_next = ST_IDLE;
                end else if (w_idle_cnt_next == IDLE_TGT) begin
                    w_state_next = ST_ACK;
`ifdef INTERN_SYNC_TIMEOUT_EN
                end else if (w_tmo_cnt_next == TMO_TGT) begin
                    w_state_next   = ST_ACK;
                    w_timeout_next = 1'b1;
`endif
                end
            end
            ST_ACK: begin
                if (i_reqn) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered copies decoded from the next state.
    assign w_ackn_next  = (w_state_next != ST_ACK);
    assign w_drain_next = (w_state_next != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_ackn     <= 1'b1;
            r_drain    <= 1'b0;
`ifdef INTERN_SYNC_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_idle_cnt_next;
            r_ackn     <= w_ackn_next;
            r_drain    <= w_drain_next;
`ifdef INTERN_SYNC_TIMEOUT_EN
            r_tmo_cnt  <= w_tmo_cnt_next;
            r_timeout  <= w_timeout_next;
`endif
        end
    end

    assign o_ackn  = r_ackn;
    assign o_drain = r_drain;
`ifdef INTERN_SYNC_TIMEOUT_EN
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/intern_sync_multi.sv
// NUM_CH independent reconfiguration synchronisers, one per region.
// Optional forced-ack timeout is enabled with macro INTERN_SYNC_TIMEOUT_EN.
module intern_sync_multi
    import intern_sync_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int IDLE_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] rc_reqn,
    input  logic [NUM_CH-1:0] rc_is_idle,
    output logic [NUM_CH-1:0] rc_ackn,
    output logic [NUM_CH-1:0] rc_drain,
    output logic [NUM_CH-1:0] rc_timeout
);

    if (NUM_CH < 1) begin : g_bad_param
        $error("intern_sync_multi: NUM_CH must be >= 1");
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        intern_sync_ch #(
            .IDLE_CYCLES    (IDLE_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .i_reqn    (rc_reqn[gi]),
            .i_is_idle (rc_is_idle[gi]),
            .o_ackn    (rc_ackn[gi]),
            .o_drain   (rc_drain[gi]),
            .o_timeout (rc_timeout[gi])
        );
    end

endmodule

// File: tb/tb_intern_sync_multi.sv
// Directed and randomized checks of intern_sync_multi against a behavioural model.
// The model follows INTERN_SYNC_TIMEOUT_EN the same way the design does.
module tb_intern_sync_multi;

    localparam int NUM_CH  = 4;
    localparam int IDLE_C  = 2;
    localparam int TMO_C   = 8;
`ifdef INTERN_SYNC_TIMEOUT_EN
    localparam bit TMO_EN  = 1'b1;
`else
    localparam bit TMO_EN  = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [NUM_CH-1:0] rc_reqn;
    logic [NUM_CH-1:0] rc_is_idle;
    logic [NUM_CH-1:0] rc_ackn;
    logic [NUM_CH-1:0] rc_drain;
    logic [NUM_CH-1:0] rc_timeout;

    intern_sync_multi #(
        .NUM_CH         (NUM_CH),
        .IDLE_CYCLES    (IDLE_C),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rc_reqn    (rc_reqn),
        .rc_is_idle (rc_is_idle),
        .rc_ackn    (rc_ackn),
        .rc_drain   (rc_drain),
        .rc_timeout (rc_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model: a channel is "busy" from an accepted request until release/abort;
    // "granted" once it has seen enough consecutive idle samples (or aged out).
    bit m_busy    [NUM_CH];
    bit m_granted [NUM_CH];
    bit m_forced  [NUM_CH];
    int m_run     [NUM_CH];
    int m_age     [NUM_CH];

    logic [NUM_CH-1:0] exp_ackn, exp_drain, exp_tmo;

    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rstn) begin
                m_busy[c] = 0; m_granted[c] = 0; m_forced[c] = 0;
                m_run[c] = 0;  m_age[c] = 0;
            end else if (!m_busy[c]) begin
                if (!rc_reqn[c]) begin
                    m_busy[c] = 1; m_granted[c] = 0; m_forced[c] = 0;
                    m_run[c] = 0;  m_age[c] = 0;
                end
            end else if (rc_reqn[c]) begin
                m_busy[c] = 0; m_granted[c] = 0;
            end else if (!m_granted[c]) begin
                m_run[c] = rc_is_idle[c] ? m_run[c] + 1 : 0;
                m_age[c] = m_age[c] + 1;
                if (m_run[c] >= IDLE_C) begin
                    m_granted[c] = 1;
                end else if (TMO_EN && m_age[c] >= TMO_C) begin
                    m_granted[c] = 1;
                    m_forced[c]  = 1;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            exp_ackn[c]  = !(m_busy[c] && m_granted[c]);
            exp_drain[c] = m_busy[c];
            exp_tmo[c]   = m_forced[c];
        end
    endfunction

    task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model with the inputs the DUT sampled, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".ackn"},    rc_ackn,    exp_ackn);
        chk({tag, ".drain"},   rc_drain,   exp_drain);
        chk({tag, ".timeout"}, rc_timeout, exp_tmo);
    endtask

    initial begin
        rstn       = 1'b0;
        rc_reqn    = '0;
        rc_is_idle = '0;

        // Reset held with requests asserted.
        for (int i = 0; i < 3; i++) begin
            tick("reset");
            chk("reset.ackn_ones", rc_ackn, {NUM_CH{1'b1}});
            chk("reset.drain_zero", rc_drain, '0);
        end
        $display("txn reset: 3 cycles, ackn=%b drain=%b timeout=%b", rc_ackn, rc_drain, rc_timeout);

        rstn       = 1'b1;
        rc_reqn    = '1;
        rc_is_idle = '1;
        tick("idle");

        // Basic handshake on ch0 with idle held high.
        rc_reqn[0] = 1'b0;
        tick("basic.E0");
        chk_bit("basic.E0.drain0", rc_drain[0], 1'b1);
        chk_bit("basic.E0.ackn0", rc_ackn[0], 1'b1);
        tick("basic.E1");
        chk_bit("basic.E1.ackn0", rc_ackn[0], 1'b1);
        tick("basic.E2");
        chk_bit("basic.E2.ackn0", rc_ackn[0], 1'b0);
        tick("basic.E3");
        tick("basic.E4");
        rc_reqn[0] = 1'b1;
        tick("basic.E5");
        chk_bit("basic.E5.ackn0", rc_ackn[0], 1'b1);
        chk_bit("basic.E5.drain0", rc_drain[0], 1'b0);
        $display("txn basic handshake ch0: ackn=%b drain=%b", rc_ackn, rc_drain);

        // Idle glitch: samples 1,0,1,1 in DRAIN; ack only after the fourth.
        rc_is_idle = 4'b1110;
        rc_reqn[0] = 1'b0;
        tick("glitch.E0");
        rc_is_idle[0] = 1'b1; tick("glitch.s1");
        rc_is_idle[0] = 1'b0; tick("glitch.s2");
        chk_bit("glitch.s2.ackn0", rc_ackn[0], 1'b1);
        rc_is_idle[0] = 1'b1; tick("glitch.s3");
        chk_bit("glitch.s3.ackn0", rc_ackn[0], 1'b1);
        tick("glitch.s4");
        chk_bit("glitch.s4.ackn0", rc_ackn[0], 1'b0);
        chk("glitch.others_quiet", rc_drain[NUM_CH-1:1], '0);
        rc_reqn[0] = 1'b1;
        tick("glitch.rel");
        $display("txn idle glitch ch0: ackn=%b drain=%b", rc_ackn, rc_drain);

        // Abort: request for one edge with idle low, then withdraw.
        rc_is_idle = '0;
        rc_reqn[0] = 1'b0;
        tick("abort.E0");
        rc_reqn[0] = 1'b1;
        tick("abort.E1");
        chk_bit("abort.E1.drain0", rc_drain[0], 1'b0);
        rc_is_idle = '1;
        for (int i = 0; i < 4; i++) begin
            tick("abort.after");
            chk_bit("abort.no_ack", rc_ackn[0], 1'b1);
        end
        $display("txn abort ch0: ackn=%b drain=%b", rc_ackn, rc_drain);

        // Concurrency: staggered requests, per-channel idle onset at 2*ch+1.
        rc_is_idle = '0;
        for (int t = 0; t < 14; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (t == c)         rc_reqn[c]    = 1'b0;
                if (t == 2 * c + 1) rc_is_idle[c] = 1'b1;
            end
            tick("conc");
        end
        chk_bit("conc.ch2_acked", rc_ackn[2], 1'b0);
        rstn = 1'b0;
        tick("conc.reset");
        chk("conc.reset.ackn", rc_ackn, {NUM_CH{1'b1}});
        chk_bit("conc.reset.ch2_ackn", rc_ackn[2], 1'b1);
        rstn    = 1'b1;
        rc_reqn = '1;
        tick("conc.idle");
        $display("txn concurrency + reset in ACK: ackn=%b drain=%b", rc_ackn, rc_drain);

        // Timeout stimulus on ch1 with idle held low.
        rc_is_idle = '0;
        rc_reqn[1] = 1'b0;
        tick("tmo.E0");
        for (int e = 1; e <= TMO_C + 2; e++) begin
            tick("tmo.wait");
            if (e == TMO_C - 1) chk_bit("tmo.before.ackn1", rc_ackn[1], 1'b1);
        end
        chk_bit("tmo.after.ackn1", rc_ackn[1], TMO_EN ? 1'b0 : 1'b1);
        chk_bit("tmo.after.flag1", rc_timeout[1], TMO_EN);
        rc_reqn[1] = 1'b1;
        tick("tmo.rel");
        rc_reqn[1] = 1'b0;
        tick("tmo.req2.E0");
        chk_bit("tmo.req2.flag_clear", rc_timeout[1], 1'b0);
        rc_reqn[1] = 1'b1;
        tick("tmo.rel2");
        $display("txn timeout ch1 (enabled=%0d): ackn=%b timeout=%b", TMO_EN, rc_ackn, rc_timeout);

        // Randomized traffic: slowly changing requests, noisy idle, rare reset.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 7) == 0) rc_reqn[c] = ~rc_reqn[c];
                rc_is_idle[c] = ($urandom_range(0, 3) != 0);
            end
            rstn = ($urandom_range(0, 63) != 0);
            tick("rand");
        end
        $display("txn random: 400 cycles, ackn=%b drain=%b timeout=%b", rc_ackn, rc_drain, rc_timeout);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
